// File: rtl/alu_ctrl.sv
// alu_ctrl: queues ALU commands, drives one ALU op at a time and returns its result and flags.
module alu_ctrl #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_a,
  input  logic [2:0] cmd_b,
  input  logic [2:0] cmd_s,
  input  logic       cmd_chain,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic [2:0] alu_s,
  input  logic [2:0] alu_out,
  input  logic       alu_zero,
  input  logic       alu_cout,
  input  logic       alu_ovf,
  input  logic       alu_neg,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [2:0] res_out,
  output logic [3:0] res_flags,
  output logic       ovf_sticky,
  input  logic       clr_sticky,
  output logic [7:0] op_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_t;
  state_t state, state_n;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push, pop, empty;
  logic [9:0] head;
  assign empty = cnt == '0;
  assign cmd_ready = cnt != (AW+1)'(FIFO_DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign head = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_n = empty ? IDLE : DRIVE;
      end
      DRIVE: state_n = CAPTURE;
      CAPTURE: state_n = HOLD;
      HOLD: if (res_ready) begin
        pop = !empty;
        state_n = empty ? IDLE : DRIVE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= {cmd_a, cmd_b, cmd_s, cmd_chain};
  // res_out doubles as the chain source: it always holds the latest capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_s <= '0;
      res_valid <= 1'b0;
      res_out <= '0;
      res_flags <= '0;
      op_count <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) begin
        alu_a <= head[0] ? res_out : head[9:7];
        alu_b <= head[6:4];
        alu_s <= head[3:1];
      end
      if (state == CAPTURE) begin
        res_out <= alu_out;
        res_flags <= {alu_neg, alu_ovf, alu_cout, alu_zero};
        op_count <= op_count + 8'd1;
      end
      res_valid <= (state == CAPTURE) ? 1'b1 : (state == HOLD && res_ready) ? 1'b0 : res_valid;
      ovf_sticky <= (state == CAPTURE && alu_ovf) ? 1'b1 : clr_sticky ? 1'b0 : ovf_sticky;
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: randomized scoreboard bench for alu_ctrl with an ALU stub and order-level reference model.
module tb_alu_ctrl;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_chain = 0;
  logic [2:0] cmd_a = 0, cmd_b = 0, cmd_s = 0;
  logic [2:0] alu_a, alu_b, alu_s, alu_out, res_out;
  logic alu_zero, alu_cout, alu_ovf, alu_neg;
  logic res_valid, res_ready = 0, ovf_sticky, clr_sticky = 0;
  logic [3:0] res_flags;
  logic [7:0] op_count;
  logic [6:0] alu_r;
  logic [6:0] exp_q[$];
  logic [2:0] last_out = 0;
  int pass_n = 0, total_n = 0;
  bit stop_rdy;

  alu_ctrl #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_ovf(alu_ovf), .alu_neg(alu_neg),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out), .res_flags(res_flags),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // ALU stub result packed as {N,V,C,Z,out[2:0]}
  function automatic logic [6:0] alu_f(input logic [2:0] a, input logic [2:0] b, input logic [2:0] s);
    logic [3:0] t;
    logic [2:0] o;
    logic c, v;
    c = 0;
    v = 0;
    case (s)
      3'd0: begin t = {1'b0, a} + {1'b0, b}; o = t[2:0]; c = t[3]; v = (a[2] == b[2]) && (o[2] != a[2]); end
      3'd1: begin t = {1'b0, a} - {1'b0, b}; o = t[2:0]; c = t[3]; v = (a[2] != b[2]) && (o[2] != a[2]); end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      default: o = ~a;
    endcase
    return {o[2], v, c, o == 3'd0, o};
  endfunction

  assign alu_r = alu_f(alu_a, alu_b, alu_s);
  assign alu_out = alu_r[2:0];
  assign {alu_neg, alu_ovf, alu_cout, alu_zero} = alu_r[6:3];

  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Results complete in acceptance order, so each chained op sees the previous op's result.
  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] s, input logic ch);
    int n;
    logic [6:0] r;
    n = 0;
    cmd_a = a; cmd_b = b; cmd_s = s; cmd_chain = ch; cmd_valid = 1;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    else begin
      r = alu_f(ch ? last_out : a, b, s);
      last_out = r[2:0];
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 2000) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_b(input logic [2:0] b);
    int n;
    n = 0;
    while (alu_b != b && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("alu_b_reached", alu_b, b);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1;
    exp_q.delete();
    last_out = 0;
    @(posedge clk);
    #1 rst = 0;
  endtask

  always @(negedge clk)
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else chk("result", {res_flags, res_out}, exp_q.pop_front());
    end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int saw;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_alu_abs", {alu_a, alu_b, alu_s}, 0);
    chk("rst_res", {res_flags, res_out}, 0);
    chk("rst_status", {ovf_sticky, op_count}, 0);
    rst = 0;
    @(posedge clk);
    #1;
    // single op, latency and flags
    send(3, 2, 0, 0);
    @(posedge clk);
    #1 chk("single_alu_abs", {alu_a, alu_b, alu_s}, {3'd3, 3'd2, 3'd0});
    chk("single_t1_valid", res_valid, 0);
    @(posedge clk);
    #1 chk("single_t2_valid", res_valid, 0);
    @(posedge clk);
    #1 chk("single_t3_valid", res_valid, 1);
    chk("single_res", {res_flags, res_out}, {4'b1100, 3'd5});
    chk("single_op_count", op_count, 1);
    chk("single_sticky", ovf_sticky, 1);
    clr_sticky = 1;
    @(posedge clk);
    #1 clr_sticky = 0;
    chk("sticky_clear", ovf_sticky, 0);
    res_ready = 1;
    wait_drain();
    // backpressure, full FIFO
    res_ready = 0;
    send(1, 2, 2, 0);
    send(5, 3, 3, 0);
    send(6, 4, 4, 0);
    @(posedge clk);
    #1 chk("full_cmd_ready", cmd_ready, 0);
    chk("full_hold_valid", res_valid, 1);
    fork
      send(7, 5, 1, 0);
      begin
        repeat (4) @(posedge clk);
        #1 res_ready = 1;
      end
    join
    wait_drain();
    chk("bp_op_count", op_count, 5);
    // chaining
    send(3, 3, 0, 0);
    send(1, 1, 0, 1);
    wait_b(1);
    chk("chain_alu_a", alu_a, 6);
    wait_drain();
    do_reset();
    send(2, 1, 0, 1);
    wait_b(1);
    chk("chain_after_rst_alu_a", alu_a, 0);
    wait_drain();
    // sticky set/clear collision
    send(3, 2, 0, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 chk("collide_pre_sticky", ovf_sticky, 0);
    clr_sticky = 1;
    @(posedge clk);
    #1 chk("collide_sticky", ovf_sticky, 1);
    @(posedge clk);
    #1 chk("clear_after_collide", ovf_sticky, 0);
    clr_sticky = 0;
    wait_drain();
    // 256 random ops with random backpressure
    do_reset();
    stop_rdy = 0;
    fork
      begin
        for (int i = 0; i < 256; i++)
          send(3'($urandom), 3'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));
        stop_rdy = 1;
      end
      while (!stop_rdy) begin
        @(posedge clk);
        #1 res_ready = 1'($urandom);
      end
    join
    res_ready = 1;
    wait_drain();
    chk("wrap_op_count", op_count, 0);
    // reset while in CAPTURE with two commands queued
    res_ready = 0;
    send(3, 2, 0, 0);
    send(1, 1, 2, 0);
    send(2, 2, 3, 0);
    rst = 1;
    exp_q.delete();
    last_out = 0;
    #1;
    chk("midrst_valid", res_valid, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_alu_abs", {alu_a, alu_b, alu_s}, 0);
    chk("midrst_status", {ovf_sticky, op_count, res_flags, res_out}, 0);
    @(posedge clk);
    #1 rst = 0;
    res_ready = 1;
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      saw |= int'(res_valid);
    end
    chk("midrst_no_result", saw, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of command FIFO entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_a (input, 3), cmd_b (input, 3), cmd_s (input, 3), cmd_chain (input, 1): the command channel.
REQ-005 SHALL have ports alu_a (output, 3), alu_b (output, 3), alu_s (output, 3): operands and selector driven to the ALU.
REQ-006 SHALL have ports alu_out (input, 3), alu_zero (input, 1), alu_cout (input, 1), alu_ovf (input, 1), alu_neg (input, 1): the ALU response.
REQ-007 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_out (output, 3), res_flags (output, 4): the result channel; res_flags = {N,V,C,Z}.
REQ-008 SHALL have ports ovf_sticky (output, 1), clr_sticky (input, 1), op_count (output, 8): status.

Function
REQ-009 SHALL accept a command on any rising edge where cmd_valid and cmd_ready are both 1.
- cmd_ready = FIFO not full.
- cmd_ready is a function of state only, never of cmd_valid.
REQ-010 SHALL store each accepted command {cmd_a, cmd_b, cmd_s, cmd_chain} in the FIFO in arrival order.
REQ-011 SHALL use FSM states IDLE, DRIVE, CAPTURE and HOLD; the reset state is IDLE.
REQ-012 IDLE: if the FIFO is non-empty, pop the head into the drive registers and go to DRIVE; otherwise stay in IDLE.
REQ-013 Drive registers:
- alu_a = last captured res_out if the popped chain bit is 1, else the popped a.
- alu_b and alu_s = the popped b and s.
- The drive registers hold their values until the next pop.
REQ-014 DRIVE: unconditionally go to CAPTURE on the next edge.
REQ-015 CAPTURE edge actions:
- Register alu_out into res_out.
- Register {alu_neg, alu_ovf, alu_cout, alu_zero} into res_flags.
- Set res_valid to 1.
- Increment op_count.
- Go to HOLD.
REQ-016 HOLD:
- res_valid, res_out and res_flags stay stable until res_valid and res_ready are both 1 on an edge.
- On that handshake edge, res_valid clears.
- The FSM then pops and goes to DRIVE if the FIFO is non-empty, otherwise goes to IDLE.
REQ-017 Latency: a command accepted at edge T into an empty FIFO while in IDLE SHALL produce res_valid = 1 after edge T+3 (pop at T+1, DRIVE to CAPTURE at T+2, capture at T+3).
REQ-018 Steady-state throughput with res_ready held at 1 SHALL be one result per 3 cycles.
REQ-019 A simultaneous push and pop on the same edge SHALL be legal.
- Occupancy is unchanged.
- Order is preserved.
- On a full FIFO, the pop frees a slot for the next cycle only; cmd_ready does not combinationally rise.
REQ-020 op_count SHALL be 8-bit unsigned and wrap from 255 to 0.
REQ-021 ovf_sticky SHALL set on a CAPTURE edge when alu_ovf = 1 and SHALL clear on an edge with clr_sticky = 1; if both happen on the same edge, set wins.
REQ-022 The chain source SHALL be the most recently captured res_out, even if that result has not yet been handshaken out (HOLD to DRIVE path).
REQ-023 The block SHALL pass flags through unmodified; logic-op flag values are whatever the ALU reports.

Reset
REQ-024 On rst = 1 the block SHALL asynchronously clear all state:
- FSM = IDLE; FIFO emptied.
- cmd_ready = 1; res_valid = 0; res_out = 0; res_flags = 0.
- alu_a/b/s = 0; ovf_sticky = 0; op_count = 0.
- Chain source = 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight commands and any pending result, with no partial output.

Verification
REQ-026 Single op: push a=3, b=2, s=000 at edge T, ALU stub returns out=5, flags N=1 V=1 C=0 Z=0 -> alu_a/b/s = 3/2/000 from T+1, res_valid=1 after T+3, res_out=5, res_flags=4'b1100, op_count=1, ovf_sticky=1.
REQ-027 Backpressure/full: res_ready=0, push 4 commands back-to-back -> cmd_ready drops after the FIFO fills (1 popped + 2 queued at depth 2), no command is lost, results emerge in order once res_ready=1.
REQ-028 Chain: op1 returns out=6; op2 has chain=1, cmd_a=1, b=1 -> alu_a=6 during op2; after reset, a chain op drives alu_a=0.
REQ-029 Sticky collision: clr_sticky=1 on the same edge as a capture with alu_ovf=1 -> ovf_sticky=1; clr_sticky=1 alone next edge -> 0.
REQ-030 Wrap and reset: 256 ops -> op_count=0; assert rst while in CAPTURE with 2 queued -> all outputs at reset values immediately, no res_valid afterwards.
